data_ram_responder: RTL
=======================

# data_ram_responder

Data-memory responder for the cqu_mips memory-access stage. Accepts one load/store request at a time from the MEM-stage initiator over a valid/ready handshake. Performs the access on an internal word-organised RAM after a configurable number of wait states, applying byte/halfword lane steering, sign/zero extension and alignment/range checking. Returns a single-cycle response that supplies the MEM stage's read-data input; the derived stall output holds the pipeline while an access is outstanding.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; legal word index is addr[31:2] < DEPTH_WORDS.
- WAIT_CYCLES, 1: wait states between accept and access, legal range 0..7.
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE and rstn high.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- rsp_valid  out  1  response valid, exactly one cycle per accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size or out-of-range access.
- stall_out  out  1  req_valid & ~rsp_valid; pipeline hold.

## Operation
- FSM states IDLE, WAIT, RESP. Accept = req_valid & req_ready at a rising edge; accept latches we/addr/wdata/size/unsigned.
- IDLE -> WAIT on accept when WAIT_CYCLES > 0, loading the wait counter with WAIT_CYCLES; IDLE -> RESP on accept when WAIT_CYCLES = 0.
- WAIT: counter decrements each cycle; at the edge where counter = 1, go to RESP.
- RESP: rsp_valid = 1 for one cycle, then IDLE unconditionally; no response backpressure.
- RAM access happens on the edge entering RESP. Store writes only enabled byte lanes. Load registers the extended result into rsp_rdata.
- Little-endian lanes. Byte lane = addr[1:0], lane 0 = bits [7:0]. Half lane = addr[1], half 0 = bits [15:0]. Store data is replicated into the selected lane.
- Error when: size = 11; half with addr[0] = 1; word with addr[1:0] != 0; or addr[31:2] >= DEPTH_WORDS. On error: no RAM write, rsp_rdata = 0, rsp_err = 1, timing unchanged.
- Initiator holds the request stable from assertion through the rsp_valid cycle. Inputs after accept are ignored. A new request is accepted no earlier than the cycle after RESP.
- Reset (rstn low at an edge) in any state: state to IDLE, any pending access dropped. A store not yet committed is never written. RAM contents are not reset.

## Timing
- Reset values: rsp_valid 0, rsp_rdata 0, rsp_err 0, FSM IDLE, counter 0. req_ready is 0 while rstn is low and 1 on the first cycle after release.
- Accept at edge E: rsp_valid is high in the cycle following edge E+WAIT_CYCLES. Latency = WAIT_CYCLES+1 cycles.
- Peak throughput is one request per WAIT_CYCLES+2 cycles.
- rsp_rdata and rsp_err hold their value outside RESP until the next RESP. They are only meaningful while rsp_valid is high.
- stall_out is combinational and is low in the RESP cycle, so the pipeline advances on the RESP edge.

## Structure
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD / SZ_BAD;
  - state encoding S_IDLE / S_WAIT / S_RESP;
  - default DEPTH_WORDS.
- Sub-module mem_lane_align (combinational) produces:
  - store byte-enables and lane-steered write data from addr[1:0], size and wdata;
  - load extraction and extension from the RAM word, addr[1:0], size and unsigned;
  - the misalign/illegal-size flag.
- Top holds the FSM, wait counter, request latch, range check and RAM array.

## Test plan
- WAIT_CYCLES=1: store word 0xDEADBEEF to 0x10, then load word 0x10 -> rsp_valid exactly 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
- Store byte 0x80 to 0x13, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
- lh at 0x12 over word 0x80ADBEEF -> 0xFFFF80AD; lhu -> 0x000080AD. sh 0x1234 to 0x10, then lw -> 0x80AD1234.
- Misalignment and range: lw at 0x11 -> err 1, rdata 0. sh at 0x13 -> err 1, word 0x10 unchanged. sw at 0x1000 with DEPTH_WORDS=1024 -> err 1, no write.
- WAIT_CYCLES=0: back-to-back requests -> accepts every 2nd cycle, rsp_valid 1 cycle after each accept, stall_out low in each RESP cycle.
- WAIT_CYCLES=3: sw 0x55 to 0x20, rstn low during WAIT, then lw 0x20 -> old contents returned (store dropped). After reset release, req_ready=1 and rsp_valid=0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared encodings and defaults for the MEM-stage data RAM responder
package mips_mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_WAIT = 2'b01, S_RESP = 2'b10} state_e;
  localparam int DEPTH_WORDS_DEF = 1024;
endpackage

// File: rtl/data_ram_responder_if.sv
// data_ram_responder_if: MEM-stage request/response bus
//   req_valid/req_ready handshake, req_we/req_addr/req_wdata/req_size/req_unsigned request fields,
//   rsp_valid/rsp_rdata/rsp_err single-cycle response, stall_out pipeline hold.
interface data_ram_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall_out;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall_out
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall_out
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane steering, load extension and misalign detection
//   i_addr low address bits, i_size access size, i_wdata right-aligned store data,
//   i_rword RAM word, i_unsigned zero-extend; o_be byte enables, o_wdata replicated
//   store data, o_rdata extended load data, o_misalign misaligned or illegal size.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  size_e       i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  input  logic        i_unsigned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);
  logic [31:0] w_sh;
  logic        w_sign;
  always_comb begin
    w_sh = i_rword >> {i_addr, 3'b000};
    o_misalign = (i_size == SZ_BAD) | (i_size == SZ_HALF & i_addr[0]) | (i_size == SZ_WORD & |i_addr);
    o_be = i_size == SZ_BYTE ? 4'b0001 << i_addr :
           i_size == SZ_HALF ? {{2{i_addr[1]}}, {2{~i_addr[1]}}} : 4'b1111;
    o_wdata = i_size == SZ_BYTE ? {4{i_wdata[7:0]}} : i_size == SZ_HALF ? {2{i_wdata[15:0]}} : i_wdata;
    w_sign = ~i_unsigned & (i_size == SZ_BYTE ? w_sh[7] : w_sh[15]);
    o_rdata = i_size == SZ_BYTE ? {{24{w_sign}}, w_sh[7:0]} :
              i_size == SZ_HALF ? {{16{w_sign}}, w_sh[15:0]} : i_rword;
  end
endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: wait-stated word RAM serving MEM-stage loads/stores
//   clk clock, rstn synchronous active-low reset, bus slave side of data_ram_responder_if.
module data_ram_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rstn,
  data_ram_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_e      r_state, w_next;
  logic [2:0]  r_cnt;
  logic        r_we, r_uns, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  size_e       r_size;
  logic [31:0] r_ram [DEPTH_WORDS];
  logic        w_idle, w_accept, w_commit, w_we, w_uns, w_mis, w_err;
  logic [31:0] w_addr, w_wdata, w_rword, w_wlane, w_ld;
  size_e       w_size;
  logic [3:0]  w_be;
  logic [AW-1:0] w_idx;
  assign w_idle   = r_state == S_IDLE;
  assign w_accept = bus.req_valid & bus.req_ready;
  // with zero wait states the access happens on the accept edge, before the latch holds the request
  assign w_we     = w_idle ? bus.req_we : r_we;
  assign w_uns    = w_idle ? bus.req_unsigned : r_uns;
  assign w_addr   = w_idle ? bus.req_addr : r_addr;
  assign w_wdata  = w_idle ? bus.req_wdata : r_wdata;
  assign w_size   = w_idle ? size_e'(bus.req_size) : r_size;
  assign w_idx    = w_addr[AW+1:2];
  assign w_rword  = r_ram[w_idx];
  assign w_err    = w_mis | ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_commit = rstn & (w_next == S_RESP) & (r_state != S_RESP);
  mem_lane_align u_align (
    .i_addr     (w_addr[1:0]),
    .i_size     (w_size),
    .i_wdata    (w_wdata),
    .i_rword    (w_rword),
    .i_unsigned (w_uns),
    .o_be       (w_be),
    .o_wdata    (w_wlane),
    .o_rdata    (w_ld),
    .o_misalign (w_mis)
  );
  always_ff @(posedge clk)
    if (!rstn) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = w_idle ? (w_accept ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE) :
             r_state == S_WAIT ? (r_cnt == 3'd1 ? S_RESP : S_WAIT) : S_IDLE;
  end
  always_comb begin
    bus.req_ready = w_idle & rstn;
    bus.rsp_valid = r_state == S_RESP;
    bus.stall_out = bus.req_valid & ~(r_state == S_RESP);
    bus.rsp_rdata = r_rdata;
    bus.rsp_err   = r_err;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      r_cnt   <= 3'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_cnt <= w_accept ? 3'(WAIT_CYCLES) : r_state == S_WAIT ? r_cnt - 3'd1 : r_cnt;
      if (w_commit) begin
        r_rdata <= (w_we | w_err) ? 32'd0 : w_ld;
        r_err   <= w_err;
      end
    end
  always_ff @(posedge clk)
    if (w_accept) begin
      r_we    <= bus.req_we;
      r_uns   <= bus.req_unsigned;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_size  <= size_e'(bus.req_size);
    end
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (w_commit & w_we & ~w_err & w_be[b]) r_ram[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
endmodule
